data_tape_engine: RTL

//  Parametrised data-side engine of the BF core: on-chip cell RAM plus data pointer (AP) and

---
 rtl/data_tape_engine.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/data_tape_engine.sv
// data_tape_engine: data side of the BF core.
// Holds the tape in on-chip RAM, the data pointer (ADDRESS) and a cached copy of
// the current cell (DATA). Arithmetic commands touch only the cached copy; the
// cache is written back to RAM and the new cell fetched whenever the pointer moves.
// Console bytes are exchanged through valid/ready handshakes.
// Build option: define DATA_TAPE_WRAP_EN to make the pointer wrap at the tape
// ends. Without it, an out-of-range move leaves the pointer in place and sets ERR.
module data_tape_engine #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DEPTH         = 30000,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     CLOCK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  input  logic [2:0]               CMD,
  output logic                     CMD_READY,
  input  logic                     IN_VALID,
  input  logic [DATA_WIDTH-1:0]    IN_DATA,
  output logic                     IN_READY,
  output logic                     OUT_VALID,
  output logic [DATA_WIDTH-1:0]    OUT_DATA,
  input  logic                     OUT_READY,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS,
  output logic [DATA_WIDTH-1:0]    DATA,
  output logic                     ZERO,
  output logic                     ERR
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_INC   = 3'd1;
  localparam logic [2:0] CMD_DEC   = 3'd2;
  localparam logic [2:0] CMD_RIGHT = 3'd3;
  localparam logic [2:0] CMD_LEFT  = 3'd4;
  localparam logic [2:0] CMD_IN    = 3'd5;
  localparam logic [2:0] CMD_OUT   = 3'd6;
  localparam logic [2:0] CMD_CLR   = 3'd7;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WB_FETCH,
    S_LOAD,
    S_IN_WAIT,
    S_OUT_WAIT
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ap_q, ap_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [ADDRESS_WIDTH-1:0] clr_q, clr_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic                     err_q, err_d;

  logic [DATA_WIDTH-1:0]    tape_ram [DEPTH];
  logic [DATA_WIDTH-1:0]    rd_data_q;
  logic                     ram_we;
  logic [RAM_AW-1:0]        ram_waddr;
  logic [DATA_WIDTH-1:0]    ram_wdata;
  logic                     accept;

  assign accept = CMD_VALID & cmd_ready_q;

  // Next-state logic: command execution, pointer moves and RAM write requests.
  always_comb begin
    state_d     = state_q;
    ap_d        = ap_q;
    data_d      = data_q;
    clr_d       = clr_q;
    cmd_ready_d = cmd_ready_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    ram_we      = 1'b0;
    ram_waddr   = ap_q[RAM_AW-1:0];
    ram_wdata   = data_q;

    case (state_q)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_q[RAM_AW-1:0];
        ram_wdata = '0;
        if (clr_q == LAST_ADDR) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
        end else begin
          clr_d = clr_q + ADDRESS_WIDTH'(1);
        end
      end

      S_IDLE: begin
        if (accept) begin
          case (CMD)
            CMD_INC: data_d = data_q + DATA_WIDTH'(1);
            CMD_DEC: data_d = data_q - DATA_WIDTH'(1);
            CMD_CLR: data_d = '0;
            CMD_RIGHT: begin
              // Dirty cached cell goes back to RAM before the pointer moves.
              ram_we      = 1'b1;
              state_d     = S_WB_FETCH;
              cmd_ready_d = 1'b0;
`ifdef DATA_TAPE_WRAP_EN
              ap_d = (ap_q == LAST_ADDR) ? '0 : ap_q + ADDRESS_WIDTH'(1);
`else
              if (ap_q == LAST_ADDR) err_d = 1'b1;
              else                   ap_d  = ap_q + ADDRESS_WIDTH'(1);
`endif
            end
            CMD_LEFT: begin
              ram_we      = 1'b1;
              state_d     = S_WB_FETCH;
              cmd_ready_d = 1'b0;
`ifdef DATA_TAPE_WRAP_EN
              ap_d = (ap_q == '0) ? LAST_ADDR : ap_q - ADDRESS_WIDTH'(1);
`else
              if (ap_q == '0) err_d = 1'b1;
              else            ap_d  = ap_q - ADDRESS_WIDTH'(1);
`endif
            end
            CMD_IN: begin
              state_d     = S_IN_WAIT;
              in_ready_d  = 1'b1;
              cmd_ready_d = 1'b0;
            end
            CMD_OUT: begin
              state_d     = S_OUT_WAIT;
              out_valid_d = 1'b1;
              out_data_d  = data_q;
              cmd_ready_d = 1'b0;
            end
            default: ; // NOP
          endcase
        end
      end

      // Pointer already updated; RAM read of the new cell happens this cycle.
      S_WB_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        data_d      = rd_data_q;
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end

      S_IN_WAIT: begin
        if (IN_VALID) begin
          data_d      = IN_DATA;
          in_ready_d  = 1'b0;
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
        end
      end

      S_OUT_WAIT: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = S_CLEAR;
        clr_d       = '0;
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any handshake and restarts the sweep.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q     <= S_CLEAR;
      ap_q        <= '0;
      data_q      <= '0;
      clr_q       <= '0;
      cmd_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ap_q        <= ap_d;
      data_q      <= data_d;
      clr_q       <= clr_d;
      cmd_ready_q <= cmd_ready_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  // Tape RAM: single write port, registered read of the cell under the pointer.
  always_ff @(posedge CLOCK) begin
    if (ram_we) tape_ram[ram_waddr] <= ram_wdata;
    rd_data_q <= tape_ram[ap_q[RAM_AW-1:0]];
  end

  assign CMD_READY = cmd_ready_q;
  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign ADDRESS   = ap_q;
  assign DATA      = data_q;
  assign ZERO      = (data_q == '0);
  assign ERR       = err_q;

endmodule
